// File: rtl/qspi_psram_pkg.sv
// Shared opcodes, FSM state encodings and page geometry for the QSPI PSRAM responder.
package qspi_psram_pkg;

    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_FAST_READ  = 8'h0B;
    localparam logic [7:0] OP_QUAD_READ  = 8'hEB;
    localparam logic [7:0] OP_WRITE      = 8'h02;
    localparam logic [7:0] OP_QUAD_WRITE = 8'h38;
    localparam logic [7:0] OP_QPI_EN     = 8'h35;
    localparam logic [7:0] OP_QPI_EX     = 8'hF5;
    localparam logic [7:0] OP_RST_EN     = 8'h66;
    localparam logic [7:0] OP_RST        = 8'h99;

    localparam int PAGE_BYTES = 1024;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_IGNORE = 3'd3;
    localparam state_t ST_DUMMY  = 3'd4;
    localparam state_t ST_RDATA  = 3'd5;
    localparam state_t ST_WDATA  = 3'd6;

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_QUAD_WRITE);
    endfunction

endpackage

// File: rtl/qspi_psram_responder_pin_sync.sv
// Synchronises ce_n, sck and dio_i into clk and produces 1-clk edge pulses.
module qspi_pin_sync
    import qspi_psram_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_n,
    input  logic       sck,
    input  logic [3:0] dio_i,
    output logic [3:0] dio_s,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_rise,
    output logic       ce_fall
);

    logic [SYNC_STAGES-1:0] ce_pipe;
    logic [SYNC_STAGES-1:0] sck_pipe;
    logic [3:0]             dio_pipe [SYNC_STAGES];
    logic                   ce_q;
    logic                   sck_q;
    logic                   ce_s;
    logic                   sck_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_pipe  <= '1;
            sck_pipe <= '0;
            ce_q     <= 1'b1;
            sck_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) dio_pipe[i] <= 4'h0;
        end else begin
            ce_pipe     <= {ce_pipe[SYNC_STAGES-2:0], ce_n};
            sck_pipe    <= {sck_pipe[SYNC_STAGES-2:0], sck};
            dio_pipe[0] <= dio_i;
            for (int i = 1; i < SYNC_STAGES; i++) dio_pipe[i] <= dio_pipe[i-1];
            ce_q        <= ce_pipe[SYNC_STAGES-1];
            sck_q       <= sck_pipe[SYNC_STAGES-1];
        end
    end

    assign ce_s  = ce_pipe[SYNC_STAGES-1];
    assign sck_s = sck_pipe[SYNC_STAGES-1];
    assign dio_s = dio_pipe[SYNC_STAGES-1];

    // sck activity only counts while the chip is selected
    assign sck_rise = sck_s & ~sck_q & ~ce_s;
    assign sck_fall = ~sck_s & sck_q & ~ce_s;
    assign ce_rise  = ce_s & ~ce_q;
    assign ce_fall  = ~ce_s & ce_q;

endmodule

// File: rtl/qspi_psram_responder.sv
// Oversampled QSPI/QPI PSRAM device model. Define PSRAM_PAGE_WRAP_EN to make
// bursts wrap inside a 1024-byte page instead of across the whole array.
module qspi_psram_responder
    import qspi_psram_pkg::*;
#(
    parameter int MEM_BYTES      = 8192,
    parameter int SYNC_STAGES    = 2,
    parameter int FAST_DUMMY_SPI = 8,
    parameter int QUAD_DUMMY     = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_n,
    input  logic       sck,
    input  logic [3:0] dio_i,
    output logic [3:0] dio_o,
    output logic [3:0] dio_oe,
    output logic       qpi_mode
);

    localparam int AW = $clog2(MEM_BYTES);

    // Handshake: none; the host owns sck and ce_n, the device samples on the
    // synchronised sck rise and updates dio_o/dio_oe on the synchronised fall.

    logic [3:0]    dio_s;
    logic          sck_rise, sck_fall, ce_rise, ce_fall;

    state_t        state;
    logic [4:0]    bit_cnt;
    logic [23:0]   sh;
    logic [7:0]    op;
    logic          quad_op;
    logic          rst_armed;
    logic [7:0]    dummy_cnt;
    logic [7:0]    out_sh;
    logic [AW-1:0] addr;
    logic [7:0]    mem [MEM_BYTES];

    logic          wide;
    logic [4:0]    lanes;
    logic [4:0]    bit_nxt;
    logic [23:0]   sh_next;
    logic [7:0]    rd_byte;
    logic [7:0]    dummy_tgt;
    logic [AW-1:0] addr_inc;
    logic          mem_we;

    qspi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce_n     (ce_n),
        .sck      (sck),
        .dio_i    (dio_i),
        .dio_s    (dio_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ce_rise  (ce_rise),
        .ce_fall  (ce_fall)
    );

`ifdef PSRAM_PAGE_WRAP_EN
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);
    assign addr_inc = (addr & ~PAGE_MASK) | ((addr + 1'b1) & PAGE_MASK);
`else
    assign addr_inc = addr + 1'b1;
`endif

    always_comb begin
        // Opcode is always single-lane in SPI mode; quad opcodes widen only later phases
        wide      = (state == ST_CMD) ? qpi_mode : (qpi_mode | quad_op);
        lanes     = wide ? 5'd4 : 5'd1;
        bit_nxt   = bit_cnt + lanes;
        sh_next   = wide ? {sh[19:0], dio_s} : {sh[22:0], dio_s[0]};
        rd_byte   = (bit_cnt == 5'd0) ? mem[addr] : out_sh;
        dummy_tgt = ((op == OP_FAST_READ) && !qpi_mode) ? 8'(FAST_DUMMY_SPI) : 8'(QUAD_DUMMY);
        mem_we    = sck_rise && (state == ST_WDATA) && (bit_nxt == 5'd8);
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= sh_next[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 5'd0;
            sh        <= 24'd0;
            op        <= 8'd0;
            quad_op   <= 1'b0;
            rst_armed <= 1'b0;
            dummy_cnt <= 8'd0;
            out_sh    <= 8'd0;
            addr      <= '0;
            dio_o     <= 4'h0;
            dio_oe    <= 4'h0;
            qpi_mode  <= 1'b0;
        end else if (ce_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= 5'd0;
            dio_o   <= 4'h0;
            dio_oe  <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_fall) begin
                        state   <= ST_CMD;
                        bit_cnt <= 5'd0;
                        quad_op <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        sh <= sh_next;
                        if (bit_nxt == 5'd8) begin
                            bit_cnt   <= 5'd0;
                            rst_armed <= (sh_next[7:0] == OP_RST_EN);
                            state     <= ST_IGNORE;
                            case (sh_next[7:0])
                                OP_READ: begin
                                    op    <= qpi_mode ? OP_FAST_READ : OP_READ;
                                    state <= ST_ADDR;
                                end
                                OP_FAST_READ, OP_WRITE: begin
                                    op    <= sh_next[7:0];
                                    state <= ST_ADDR;
                                end
                                OP_QUAD_READ, OP_QUAD_WRITE: begin
                                    op      <= sh_next[7:0];
                                    quad_op <= 1'b1;
                                    state   <= ST_ADDR;
                                end
                                OP_QPI_EN: qpi_mode <= 1'b1;
                                OP_QPI_EX: qpi_mode <= 1'b0;
                                OP_RST:    if (rst_armed) qpi_mode <= 1'b0;
                                default:   ;
                            endcase
                        end else begin
                            bit_cnt <= bit_nxt;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        sh <= sh_next;
                        if (bit_nxt == 5'd24) begin
                            addr      <= sh_next[AW-1:0];
                            bit_cnt   <= 5'd0;
                            dummy_cnt <= 8'd0;
                            if (is_write_op(op))    state <= ST_WDATA;
                            else if (op == OP_READ) state <= ST_RDATA;
                            else                    state <= ST_DUMMY;
                        end else begin
                            bit_cnt <= bit_nxt;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_rise) begin
                        if (dummy_cnt + 8'd1 == dummy_tgt) state <= ST_RDATA;
                        else dummy_cnt <= dummy_cnt + 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        dio_o   <= wide ? rd_byte[7:4] : {2'b00, rd_byte[7], 1'b0};
                        dio_oe  <= wide ? 4'hF : 4'b0010;
                        out_sh  <= wide ? {rd_byte[3:0], 4'h0} : {rd_byte[6:0], 1'b0};
                        // Address advances as each new byte is fetched
                        if (bit_cnt == 5'd0) addr <= addr_inc;
                        bit_cnt <= (bit_nxt == 5'd8) ? 5'd0 : bit_nxt;
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        sh <= sh_next;
                        if (bit_nxt == 5'd8) begin
                            addr    <= addr_inc;
                            bit_cnt <= 5'd0;
                        end else begin
                            bit_cnt <= bit_nxt;
                        end
                    end
                end
                ST_IGNORE: dio_oe <= 4'h0;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_psram_responder.sv
// Directed bench for qspi_psram_responder: SPI/QPI reads and writes, wrap, abort and reset.
module tb_qspi_psram_responder;

    localparam int CLK = 10;
    localparam int HP  = 60;
`ifdef PSRAM_PAGE_WRAP_EN
    localparam logic [23:0] WRAP_BASE = 24'h0003FF;
`else
    localparam logic [23:0] WRAP_BASE = 24'h001FFF;
`endif

    logic       clk;
    logic       rst_n;
    logic       ce_n;
    logic       sck;
    logic [3:0] dio_i;
    logic [3:0] dio_o;
    logic [3:0] dio_oe;
    logic       qpi_mode;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rv;
    logic       oe_ok;

    qspi_psram_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce_n     (ce_n),
        .sck      (sck),
        .dio_i    (dio_i),
        .dio_o    (dio_o),
        .dio_oe   (dio_oe),
        .qpi_mode (qpi_mode)
    );

    initial clk = 1'b0;
    always #(CLK/2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sck_pulse(input logic [3:0] d);
        dio_i = d;
        #HP sck = 1'b1;
        #HP sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit wide);
        if (wide) begin
            sck_pulse(b[7:4]);
            sck_pulse(b[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) sck_pulse({3'b000, b[i]});
        end
    endtask

    task automatic send_addr(input logic [23:0] a, input bit wide);
        send_byte(a[23:16], wide);
        send_byte(a[15:8], wide);
        send_byte(a[7:0], wide);
    endtask

    task automatic dummy(input int n);
        for (int i = 0; i < n; i++) sck_pulse(4'h0);
    endtask

    // Samples just before each rise, after the device has reacted to the previous fall
    task automatic read_units(input int n, input bit wide, output logic [7:0] val, output logic ok);
        val   = 8'h00;
        ok    = 1'b1;
        dio_i = 4'h0;
        for (int i = 0; i < n; i++) begin
            #HP;
            if (dio_oe !== (wide ? 4'hF : 4'b0010)) ok = 1'b0;
            val = wide ? {val[3:0], dio_o} : {val[6:0], dio_o[1]};
            sck = 1'b1;
            #HP sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        ce_n = 1'b0;
        #(4*CLK);
    endtask

    task automatic cs_end();
        #HP ce_n = 1'b1;
        #(8*CLK);
    endtask

    task automatic spi_write1(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input bit two);
        cs_begin();
        send_byte(8'h02, 1'b0);
        send_addr(a, 1'b0);
        send_byte(d0, 1'b0);
        if (two) send_byte(d1, 1'b0);
        cs_end();
    endtask

    task automatic spi_read1(input logic [23:0] a, output logic [7:0] val, output logic ok);
        cs_begin();
        send_byte(8'h03, 1'b0);
        send_addr(a, 1'b0);
        read_units(8, 1'b0, val, ok);
        cs_end();
    endtask

    initial begin
        rst_n = 1'b0;
        ce_n  = 1'b1;
        sck   = 1'b0;
        dio_i = 4'h0;
        #(5*CLK);
        check("reset_dio_oe", dio_oe, 4'h0);
        check("reset_dio_o", dio_o, 4'h0);
        check("reset_qpi", qpi_mode, 1'b0);
        rst_n = 1'b1;
        #(5*CLK);

        // SPI write A5 3C at 0x10, then read back
        spi_write1(24'h000010, 8'hA5, 8'h3C, 1'b1);
        check("spi_wr_oe_idle", dio_oe, 4'h0);
        cs_begin();
        send_byte(8'h03, 1'b0);
        check("spi_rd_oe_cmd", dio_oe, 4'h0);
        send_addr(24'h000010, 1'b0);
        read_units(8, 1'b0, rv, oe_ok);
        check("spi_rd_b0", rv, 8'hA5);
        check("spi_rd_b0_oe", oe_ok, 1'b1);
        read_units(8, 1'b0, rv, oe_ok);
        check("spi_rd_b1", rv, 8'h3C);
        check("spi_rd_b1_oe", oe_ok, 1'b1);
        cs_end();
        check("spi_rd_oe_after", dio_oe, 4'h0);

        // Quad write 12 34 56 at 0x100, quad read with 6 dummy
        cs_begin();
        send_byte(8'h38, 1'b0);
        send_addr(24'h000100, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        cs_end();
        cs_begin();
        send_byte(8'hEB, 1'b0);
        send_addr(24'h000100, 1'b1);
        dummy(6);
        read_units(2, 1'b1, rv, oe_ok);
        check("quad_rd_b0", rv, 8'h12);
        check("quad_rd_b0_oe", oe_ok, 1'b1);
        read_units(2, 1'b1, rv, oe_ok);
        check("quad_rd_b1", rv, 8'h34);
        read_units(2, 1'b1, rv, oe_ok);
        check("quad_rd_b2", rv, 8'h56);
        check("quad_rd_b2_oe", oe_ok, 1'b1);
        cs_end();

        // Enter QPI, fast read in QPI with 6 dummy
        cs_begin();
        send_byte(8'h35, 1'b0);
        cs_end();
        check("qpi_enter", qpi_mode, 1'b1);
        cs_begin();
        send_byte(8'h0B, 1'b1);
        send_addr(24'h000100, 1'b1);
        dummy(6);
        read_units(2, 1'b1, rv, oe_ok);
        check("qpi_fast_b0", rv, 8'h12);
        check("qpi_fast_b0_oe", oe_ok, 1'b1);
        read_units(2, 1'b1, rv, oe_ok);
        check("qpi_fast_b1", rv, 8'h34);
        cs_end();

        // Reset-enable then reset leaves QPI
        cs_begin();
        send_byte(8'h66, 1'b1);
        cs_end();
        check("rst_en_keeps_qpi", qpi_mode, 1'b1);
        cs_begin();
        send_byte(8'h99, 1'b1);
        cs_end();
        check("rst_exits_qpi", qpi_mode, 1'b0);
        spi_read1(24'h000010, rv, oe_ok);
        check("spi_after_rst", rv, 8'hA5);
        check("spi_after_rst_oe", oe_ok, 1'b1);

        // Burst wrap: second byte lands at address 0
        spi_write1(WRAP_BASE, 8'hFF, 8'h00, 1'b1);
        spi_read1(WRAP_BASE, rv, oe_ok);
        check("wrap_last", rv, 8'hFF);
        spi_read1(24'h000000, rv, oe_ok);
        check("wrap_first", rv, 8'h00);

        // Aborted write after 4 bits leaves the byte intact
        spi_write1(24'h000020, 8'h5A, 8'h00, 1'b0);
        cs_begin();
        send_byte(8'h02, 1'b0);
        send_addr(24'h000020, 1'b0);
        for (int i = 0; i < 4; i++) sck_pulse(4'h1);
        cs_end();
        spi_read1(24'h000020, rv, oe_ok);
        check("abort_wr_kept", rv, 8'h5A);

        // Async reset during a QPI read
        cs_begin();
        send_byte(8'h35, 1'b0);
        cs_end();
        cs_begin();
        send_byte(8'h03, 1'b1);
        send_addr(24'h000010, 1'b1);
        dummy(6);
        read_units(1, 1'b1, rv, oe_ok);
        check("rst_mid_nib", rv, 8'h0A);
        check("rst_mid_oe_before", dio_oe, 4'hF);
        rst_n = 1'b0;
        #CLK;
        check("rst_mid_oe", dio_oe, 4'h0);
        check("rst_mid_qpi", qpi_mode, 1'b0);
        check("rst_mid_dio", dio_o, 4'h0);
        rst_n = 1'b1;
        cs_end();

        // Unknown opcode keeps the bus released
        cs_begin();
        send_byte(8'h9F, 1'b0);
        oe_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sck_pulse(4'h0);
            #HP;
            if (dio_oe !== 4'h0) oe_ok = 1'b0;
        end
        check("unknown_op_oe", oe_ok, 1'b1);
        cs_end();
        check("unknown_op_oe_after", dio_oe, 4'h0);
        spi_read1(24'h000011, rv, oe_ok);
        check("after_unknown_rd", rv, 8'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_psram_responder.md
Name: qspi_psram_responder

Overview:
Synthesizable QSPI PSRAM device model that runs on the system clock and oversamples the SPI pins, for FPGA-in-loop and gate-level benches. It generalises the bench PSRAM model with a parametrised size, SPI and QPI modes, a dummy-cycle table, reset-enable/reset, and an optional page wrap. It attaches to the same ce_n, sck and 4-bit dio bus as the flash and PSRAM models on the uio pins.

Parameters:
MEM_BYTES, 8192, memory size in bytes; must be a power of 2; address taken modulo this.
SYNC_STAGES, 2, synchroniser depth for ce_n, sck and dio_i (minimum 2).
FAST_DUMMY_SPI, 8, dummy sck cycles for 0x0B in SPI mode.
QUAD_DUMMY, 6, dummy sck cycles for 0xEB (SPI or QPI), and for 0x0B in QPI mode.

Ports:
clk  input  1  system clock; must be at least 4x the sck frequency.
rst_n  input  1  asynchronous active-low reset.
ce_n  input  1  chip select, active low.
sck  input  1  SPI clock; mode 0.
dio_i  input  4  data in; bit 0 is SI in SPI mode.
dio_o  output  4  data out; bit 1 is SO in SPI mode.
dio_oe  output  4  output enables.
qpi_mode  output  1  1 while the device is in QPI mode.

Behaviour:
- Reset: dio_o=0, dio_oe=0, qpi_mode=0, state IDLE, all counters cleared. Memory contents are not cleared.
- Pin capture:
  - ce_n, sck and dio_i pass through SYNC_STAGES flops.
  - Edge detects are taken on the synchronised sck.
  - Each detected rise or fall is a 1-clk pulse. Pin-to-action latency is SYNC_STAGES+1 clk.
- Lanes per edge:
  - SPI mode: 1 lane, input on dio_i[0], output on dio_o[1] with dio_oe=4'b0010.
  - QPI mode, and the address/data phases of 0xEB and 0x38: 4 lanes with dio_oe=4'hF while driving.
  - Everything is MSB first.
- Input sampling happens on sck rise. Output updates happen on sck fall.
- States: IDLE -> CMD -> {ADDR, IGNORE} -> {DUMMY, RDATA, WDATA}.
- IDLE:
  - Falling synchronised ce_n -> CMD.
  - Bit counter cleared.
- CMD:
  - Collects 8 bits: 8 rises in SPI mode, 2 rises in QPI mode.
  - Decode:
    - 0x03 read, 0x0B fast read, 0xEB quad read, 0x02 write, 0x38 quad write -> ADDR.
    - 0x35 -> qpi_mode=1, then IGNORE.
    - 0xF5 -> qpi_mode=0, then IGNORE.
    - 0x66 -> sets rst_armed, then IGNORE.
    - 0x99 with rst_armed -> qpi_mode=0, then IGNORE.
    - Any other opcode -> IGNORE. Any opcode other than 0x66 clears rst_armed.
- ADDR:
  - 24 bits; bits above log2(MEM_BYTES) are dropped.
  - Next state after the last address bit: reads with dummy -> DUMMY; 0x03 -> RDATA; writes -> WDATA.
  - 0x03 in QPI mode is treated as 0x0B.
- DUMMY:
  - Counts rises: FAST_DUMMY_SPI for 0x0B in SPI; QUAD_DUMMY for 0xEB and for 0x0B in QPI.
  - Then -> RDATA.
- RDATA:
  - On the sck fall following the last address or dummy rise: load mem[addr] and drive its MSB bit or nibble, set dio_oe.
  - Each further fall shifts out the next bit or nibble.
  - After the last bit of a byte, the next fall outputs mem[addr+1].
- WDATA:
  - Assembles a byte across 8 or 2 rises.
  - Writes mem[addr] in the clk of the completing rise, then increments addr.
- Address increment: wraps at MEM_BYTES.
- IGNORE: dio_oe=0; waits for ce_n high.
- ce_n rising (synchronised), in any state:
  - Next clk: state IDLE, dio_oe=0.
  - Any partially assembled write byte is discarded.
  - qpi_mode and rst_armed are kept.
- sck edges while ce_n is high are ignored.
- rst_n asserted mid-transfer: immediate return to reset values. No write in progress completes.

Optional Feature:
PSRAM_PAGE_WRAP_EN:
- Defined: burst addresses wrap within a 1024-byte page. addr[9:0] increments; upper bits are held. MEM_BYTES must be at least 1024.
- Undefined: linear increment wrapping at MEM_BYTES.

Decomposition:
- Package qspi_psram_pkg:
  - opcode constants: OP_READ 8'h03, OP_FAST_READ 8'h0B, OP_QUAD_READ 8'hEB, OP_WRITE 8'h02, OP_QUAD_WRITE 8'h38, OP_QPI_EN 8'h35, OP_QPI_EX 8'hF5, OP_RST_EN 8'h66, OP_RST 8'h99.
  - state enum.
  - page size constant 1024.
- Sub-module qspi_pin_sync: the SYNC_STAGES synchroniser plus the sck rise/fall and ce_n edge pulses.

Test Plan:
- SPI 0x02 at 0x000010 writing A5 3C, then 0x03 at 0x000010 -> dio_o[1] shifts A5 3C MSB first; dio_oe=4'b0010 only during data.
- 0x38 at 0x000100 writing 12 34 56, then 0xEB at the same address with 6 dummy -> nibbles 1,2,3,4,5,6 on dio_o; dio_oe=F from the first data fall.
- 0x35, then a QPI-mode 0x0B at 0x000100 with 6 dummy -> 12 34; qpi_mode=1. Then 0x66, 0x99 -> qpi_mode=0; a following SPI 0x03 works.
- Write FF at MEM_BYTES-1 plus 1 more byte (00) -> 00 lands at address 0. With PSRAM_PAGE_WRAP_EN: write at 0x3FF then 0x000 -> the second byte lands at 0x000.
- ce_n raised after 4 of the 8 write bits -> the target byte is unchanged; the next command decodes correctly.
- rst_n pulsed mid-read -> dio_oe=0 within 1 clk, qpi_mode=0; unknown opcode 0x9F -> dio_oe stays 0 until ce_n high.
